// File: rtl/riscv_mul_issue_ctrl_pkg.sv
// Shared M-extension opcode values/masks, issue FSM state type and decode helper
// for riscv_mul_issue_ctrl.
package riscv_mul_issue_ctrl_pkg;

  localparam logic [31:0] INST_MUL         = 32'h02000033;
  localparam logic [31:0] INST_MUL_MASK    = 32'hfe00707f;
  localparam logic [31:0] INST_MULH        = 32'h02001033;
  localparam logic [31:0] INST_MULH_MASK   = 32'hfe00707f;
  localparam logic [31:0] INST_MULHSU      = 32'h02002033;
  localparam logic [31:0] INST_MULHSU_MASK = 32'hfe00707f;
  localparam logic [31:0] INST_MULHU       = 32'h02003033;
  localparam logic [31:0] INST_MULHU_MASK  = 32'hfe00707f;

  typedef enum logic [1:0] {
    MULISS_IDLE,
    MULISS_ISSUE,
    MULISS_WAIT,
    MULISS_RESP
  } mul_iss_state_e;

  function automatic logic is_mul_op(input logic [31:0] op);
    return ((op & INST_MUL_MASK)    == INST_MUL)    ||
           ((op & INST_MULH_MASK)   == INST_MULH)   ||
           ((op & INST_MULHSU_MASK) == INST_MULHSU) ||
           ((op & INST_MULHU_MASK)  == INST_MULHU);
  endfunction

endpackage

// File: rtl/riscv_mul_issue_ctrl.sv
// Issue/response controller for the fixed-latency riscv_multiplier, one transaction in flight.
// Optional: define RISCV_MUL_DECODE_CHECK_EN to reject non-MUL opcodes with resp_err_o.
module riscv_mul_issue_ctrl
  import riscv_mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_opcode_i,
  input  logic [31:0] req_pc_i,
  input  logic [4:0]  req_rd_idx_i,
  input  logic [31:0] req_ra_operand_i,
  input  logic [31:0] req_rb_operand_i,
  input  logic        stall_i,
  output logic        opcode_valid_o,
  output logic [31:0] opcode_opcode_o,
  output logic [31:0] opcode_pc_o,
  output logic        opcode_invalid_o,
  output logic [4:0]  opcode_rd_idx_o,
  output logic [4:0]  opcode_ra_idx_o,
  output logic [4:0]  opcode_rb_idx_o,
  output logic [31:0] opcode_ra_operand_o,
  output logic [31:0] opcode_rb_operand_o,
  output logic        hold_o,
  input  logic [31:0] writeback_value_i,
  input  logic        busy_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_value_o,
  output logic [4:0]  resp_rd_idx_o,
  output logic [31:0] resp_pc_o,
  output logic        resp_err_o
);

  mul_iss_state_e state_q;
  logic [2:0]     cnt_q;
  logic           decode_err;

`ifdef RISCV_MUL_DECODE_CHECK_EN
  assign decode_err = !is_mul_op(req_opcode_i);
`else
  assign decode_err = 1'b0;
`endif

  // Ready is masked by reset so nothing can be accepted while rst_i is low.
  assign req_ready_o      = rst_i && (state_q == MULISS_IDLE) && !busy_i && !stall_i;
  assign hold_o           = stall_i;
  assign opcode_invalid_o = 1'b0;
  assign opcode_ra_idx_o  = opcode_opcode_o[19:15];
  assign opcode_rb_idx_o  = opcode_opcode_o[24:20];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q             <= MULISS_IDLE;
      cnt_q               <= '0;
      opcode_valid_o      <= 1'b0;
      opcode_opcode_o     <= '0;
      opcode_pc_o         <= '0;
      opcode_rd_idx_o     <= '0;
      opcode_ra_operand_o <= '0;
      opcode_rb_operand_o <= '0;
      resp_valid_o        <= 1'b0;
      resp_value_o        <= '0;
      resp_rd_idx_o       <= '0;
      resp_pc_o           <= '0;
      resp_err_o          <= 1'b0;
    end else begin
      case (state_q)
        MULISS_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            opcode_opcode_o     <= req_opcode_i;
            opcode_pc_o         <= req_pc_i;
            opcode_rd_idx_o     <= req_rd_idx_i;
            opcode_ra_operand_o <= req_ra_operand_i;
            opcode_rb_operand_o <= req_rb_operand_i;
            if (decode_err) begin
              // Rejected opcodes bypass the multiplier and answer on the next cycle.
              resp_valid_o  <= 1'b1;
              resp_value_o  <= '0;
              resp_rd_idx_o <= req_rd_idx_i;
              resp_pc_o     <= req_pc_i;
              resp_err_o    <= 1'b1;
              state_q       <= MULISS_RESP;
            end else begin
              opcode_valid_o <= 1'b1;
              state_q        <= MULISS_ISSUE;
            end
          end
        end
        MULISS_ISSUE: begin
          if (!stall_i) begin
            opcode_valid_o <= 1'b0;
            cnt_q          <= 3'(MUL_LATENCY);
            state_q        <= MULISS_WAIT;
          end
        end
        MULISS_WAIT: begin
          if (!stall_i) begin
            if (cnt_q == 3'd1) begin
              resp_valid_o  <= 1'b1;
              resp_value_o  <= writeback_value_i;
              resp_rd_idx_o <= opcode_rd_idx_o;
              resp_pc_o     <= opcode_pc_o;
              resp_err_o    <= 1'b0;
              state_q       <= MULISS_RESP;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
        end
        MULISS_RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state_q      <= MULISS_IDLE;
          end
        end
        default: state_q <= MULISS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mul_issue_ctrl.sv
// Directed bench for riscv_mul_issue_ctrl with a fixed-latency multiplier model and a
// response scoreboard.
module tb_riscv_mul_issue_ctrl;

  localparam int unsigned LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_opcode_i;
  logic [31:0] req_pc_i;
  logic [4:0]  req_rd_idx_i;
  logic [31:0] req_ra_operand_i;
  logic [31:0] req_rb_operand_i;
  logic        stall_i;
  logic        opcode_valid_o;
  logic [31:0] opcode_opcode_o;
  logic [31:0] opcode_pc_o;
  logic        opcode_invalid_o;
  logic [4:0]  opcode_rd_idx_o;
  logic [4:0]  opcode_ra_idx_o;
  logic [4:0]  opcode_rb_idx_o;
  logic [31:0] opcode_ra_operand_o;
  logic [31:0] opcode_rb_operand_o;
  logic        hold_o;
  logic [31:0] writeback_value_i;
  logic        busy_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_value_o;
  logic [4:0]  resp_rd_idx_o;
  logic [31:0] resp_pc_o;
  logic        resp_err_o;

  riscv_mul_issue_ctrl #(.MUL_LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opcode_i(req_opcode_i), .req_pc_i(req_pc_i), .req_rd_idx_i(req_rd_idx_i),
    .req_ra_operand_i(req_ra_operand_i), .req_rb_operand_i(req_rb_operand_i),
    .stall_i(stall_i),
    .opcode_valid_o(opcode_valid_o), .opcode_opcode_o(opcode_opcode_o),
    .opcode_pc_o(opcode_pc_o), .opcode_invalid_o(opcode_invalid_o),
    .opcode_rd_idx_o(opcode_rd_idx_o), .opcode_ra_idx_o(opcode_ra_idx_o),
    .opcode_rb_idx_o(opcode_rb_idx_o), .opcode_ra_operand_o(opcode_ra_operand_o),
    .opcode_rb_operand_o(opcode_rb_operand_o), .hold_o(hold_o),
    .writeback_value_i(writeback_value_i), .busy_i(busy_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_value_o(resp_value_o), .resp_rd_idx_o(resp_rd_idx_o),
    .resp_pc_o(resp_pc_o), .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  int issues = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(posedge clk_i) if (opcode_valid_o && !hold_o) issues <= issues + 1;

  function automatic logic [31:0] mul_model(input logic [31:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [2:0]  f3;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    f3 = op[14:12];
    case (f3)
      3'd0:    begin p = ua * ub; return p[31:0]; end
      3'd1:    begin p = sa * sb; return p[63:32]; end
      3'd2:    begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  // Multiplier stand-in: result visible only on the last cycle of its hold-aware latency.
  int unsigned m_cnt = 0;
  logic [31:0] m_res = '0;
  always @(posedge clk_i) begin
    if (opcode_valid_o && !hold_o) begin
      m_cnt <= LAT;
      m_res <= mul_model(opcode_opcode_o, opcode_ra_operand_o, opcode_rb_operand_o);
    end else if (m_cnt != 0 && !hold_o) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign writeback_value_i = (m_cnt == 1) ? m_res : 32'hDEADBEEF;

  function automatic logic [31:0] mk_op(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] v, input logic [4:0] rd, input logic [31:0] pc,
                      input logic err);
    exp_t e;
    e.value = v; e.rd = rd; e.pc = pc; e.err = err;
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] op, input logic [31:0] pc, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] b, output int acc);
    req_opcode_i = op; req_pc_i = pc; req_rd_idx_i = rd;
    req_ra_operand_i = a; req_rb_operand_i = b;
    req_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (req_ready_o) break;
    end
    if (!req_ready_o) chk("req_ready_timeout", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    acc = cyc;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int exp_cyc);
    logic got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (resp_valid_o) begin got = 1'b1; break; end
    end
    chk({tag, "_valid"}, {31'd0, got}, 32'd1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_cycle"}, cyc, exp_cyc);
      chk({tag, "_value"}, resp_value_o, e.value);
      chk({tag, "_rd"}, {27'd0, resp_rd_idx_o}, {27'd0, e.rd});
      chk({tag, "_pc"}, resp_pc_o, e.pc);
      chk({tag, "_err"}, {31'd0, resp_err_o}, {31'd0, e.err});
      if (resp_ready_i) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  initial begin
    int acc;
    int iss0;
    logic seen;
    logic [31:0] op, a, b;

    rst_i = 1'b0; stall_i = 1'b1; busy_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b1;
    req_opcode_i = '0; req_pc_i = '0; req_rd_idx_i = '0;
    req_ra_operand_i = '0; req_rb_operand_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_opcode_valid", {31'd0, opcode_valid_o}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst_resp_value", resp_value_o, 32'd0);
    chk("rst_hold_follows_stall", {31'd0, hold_o}, 32'd1);
    stall_i = 1'b0;
    @(negedge clk_i);
    chk("rst_hold_low", {31'd0, hold_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // Acceptance gating in IDLE
    busy_i = 1'b1;
    @(negedge clk_i);
    chk("idle_busy_ready", {31'd0, req_ready_o}, 32'd0);
    busy_i = 1'b0; stall_i = 1'b1;
    @(negedge clk_i);
    chk("idle_stall_ready", {31'd0, req_ready_o}, 32'd0);
    stall_i = 1'b0;
    @(negedge clk_i);
    chk("idle_ready", {31'd0, req_ready_o}, 32'd1);

    // MUL 3*7 with latency check and opcode field forwarding
    op = mk_op(3'd0, 5'd3, 5'd1, 5'd2);
    send(op, 32'h0000_0100, 5'd3, 32'd3, 32'd7, acc);
    push(32'h0000_0015, 5'd3, 32'h0000_0100, 1'b0);
    @(negedge clk_i);
    chk("issue_valid", {31'd0, opcode_valid_o}, 32'd1);
    chk("issue_opcode", opcode_opcode_o, op);
    chk("issue_ra_idx", {27'd0, opcode_ra_idx_o}, 32'd1);
    chk("issue_rb_idx", {27'd0, opcode_rb_idx_o}, 32'd2);
    chk("issue_rd_idx", {27'd0, opcode_rd_idx_o}, 32'd3);
    chk("issue_invalid", {31'd0, opcode_invalid_o}, 32'd0);
    @(negedge clk_i);
    chk("wait_opcode_valid", {31'd0, opcode_valid_o}, 32'd0);
    wait_resp("mul", acc + 1 + LAT);

    // MULH -2*7, busy_i asserted during WAIT must not delay it
    send(mk_op(3'd1, 5'd4, 5'd5, 5'd6), 32'h0000_0104, 5'd4, 32'hFFFF_FFFE, 32'd7, acc);
    push(32'hFFFF_FFFF, 5'd4, 32'h0000_0104, 1'b0);
    busy_i = 1'b1;
    wait_resp("mulh", acc + 1 + LAT);
    busy_i = 1'b0;

    send(mk_op(3'd3, 5'd7, 5'd8, 5'd9), 32'h0000_0108, 5'd7, 32'hFFFF_0000, 32'h0000_FFFF, acc);
    push(32'h0000_FFFE, 5'd7, 32'h0000_0108, 1'b0);
    wait_resp("mulhu", acc + 1 + LAT);

    send(mk_op(3'd2, 5'd10, 5'd11, 5'd12), 32'h0000_010C, 5'd10, 32'hFFFF_FFFF, 32'd2, acc);
    push(32'hFFFF_FFFF, 5'd10, 32'h0000_010C, 1'b0);
    wait_resp("mulhsu", acc + 1 + LAT);

    // Back-pressure on the response port
    resp_ready_i = 1'b0;
    send(mk_op(3'd0, 5'd13, 5'd14, 5'd15), 32'h0000_0110, 5'd13, 32'd5, 32'd6, acc);
    push(32'h0000_001E, 5'd13, 32'h0000_0110, 1'b0);
    wait_resp("bp", acc + 1 + LAT);
    iss0 = issues;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_valid", {31'd0, resp_valid_o}, 32'd1);
      chk("bp_value", resp_value_o, 32'h0000_001E);
      chk("bp_rd", {27'd0, resp_rd_idx_o}, 32'd13);
      chk("bp_req_ready", {31'd0, req_ready_o}, 32'd0);
    end
    chk("bp_no_reissue", issues, iss0);
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("bp_released", {31'd0, resp_valid_o}, 32'd0);

    // Three stalled cycles during WAIT delay the response by exactly three
    send(mk_op(3'd0, 5'd16, 5'd17, 5'd18), 32'h0000_0114, 5'd16, 32'd1000, 32'd1000, acc);
    push(32'd1000000, 5'd16, 32'h0000_0114, 1'b0);
    @(posedge clk_i); #1;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_hold", {31'd0, hold_o}, 32'd1);
    end
    @(posedge clk_i); #1;
    stall_i = 1'b0;
    wait_resp("stall", acc + 1 + LAT + 3);

    // Reset during WAIT drops the transaction
    send(mk_op(3'd0, 5'd19, 5'd20, 5'd21), 32'h0000_0118, 5'd19, 32'd9, 32'd9, acc);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (resp_valid_o) seen = 1'b1;
    end
    chk("rst_wait_no_resp", {31'd0, seen}, 32'd0);
    chk("rst_wait_idle_ready", {31'd0, req_ready_o}, 32'd1);

    // Randomised operands across all four ops
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      op = mk_op(3'($urandom_range(0, 3)), 5'(i + 1), 5'd1, 5'd2);
      send(op, 32'h0000_0200 + 32'(i * 4), 5'(i + 1), a, b, acc);
      push(mul_model(op, a, b), 5'(i + 1), 32'h0000_0200 + 32'(i * 4), 1'b0);
      wait_resp("rand", acc + 1 + LAT);
    end

`ifdef RISCV_MUL_DECODE_CHECK_EN
    iss0 = issues;
    send(32'h0000_0033, 32'h0000_0300, 5'd22, 32'd1, 32'd2, acc);
    push(32'd0, 5'd22, 32'h0000_0300, 1'b1);
    chk("dec_opcode_valid", {31'd0, opcode_valid_o}, 32'd0);
    wait_resp("dec_err", acc);
    chk("dec_no_issue", issues, iss0);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
